// File: rtl/mem_read_initiator.sv
// Requester side of the synchronous memory read interface: one command at a time,
// single-cycle memValid strobe, extended result. Optional macro: MEM_MISALIGN_CHECK_EN.
`ifndef MEM_WIDTH_NONE
`define MEM_WIDTH_NONE 2'd0
`endif
`ifndef MEM_WIDTH_BYTE
`define MEM_WIDTH_BYTE 2'd1
`endif
`ifndef MEM_WIDTH_HALF
`define MEM_WIDTH_HALF 2'd2
`endif
`ifndef MEM_WIDTH_WORD
`define MEM_WIDTH_WORD 2'd3
`endif
`ifndef EXCEPTION_LEN
`define EXCEPTION_LEN 4
`endif
`ifndef EXCEP_OK
`define EXCEP_OK 4'd0
`endif
`ifndef EXCEP_INVALID_MEM_READ
`define EXCEP_INVALID_MEM_READ 4'd4
`endif

module mem_read_initiator #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_In,
  input  logic [31:0]               addr_In,
  input  logic [1:0]                dataWidth_In,
  input  logic                      unsigned_In,
  output logic                      ready_Out,
  output logic [31:0]               result_Out,
  output logic                      done_Out,
  output logic [`EXCEPTION_LEN-1:0] exception_Out,
  output logic [31:0]               memAddr_Out,
  output logic [1:0]                memWidth_Out,
  output logic                      memValid_Out,
  input  logic [31:0]               memData_In,
  input  logic                      memOK_In,
  input  logic [`EXCEPTION_LEN-1:0] memException_In
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_e;

  state_e                    state_q, state_d;
  logic [31:0]               addr_q, addr_d;
  logic [1:0]                width_q, width_d;
  logic                      uns_q, uns_d;
  logic                      valid_q, valid_d;
  logic                      done_q, done_d;
  logic [31:0]               result_q, result_d;
  logic [`EXCEPTION_LEN-1:0] exc_q, exc_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [31:0]               ext;
  logic                      misalign;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign =
    ((dataWidth_In == `MEM_WIDTH_HALF) && addr_In[0]) ||
    ((dataWidth_In == `MEM_WIDTH_WORD) && (addr_In[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign ready_Out     = (state_q == S_IDLE);
  assign result_Out    = result_q;
  assign done_Out      = done_q;
  assign exception_Out = exc_q;
  assign memAddr_Out   = addr_q;
  assign memWidth_Out  = width_q;
  assign memValid_Out  = valid_q;

  // Right-aligned item extended per the latched width and signedness
  always_comb begin
    case (width_q)
      `MEM_WIDTH_BYTE:
        ext = {{24{~uns_q & memData_In[7]}}, memData_In[7:0]};
      `MEM_WIDTH_HALF:
        ext = {{16{~uns_q & memData_In[15]}}, memData_In[15:0]};
      default:
        ext = memData_In;
    endcase
  end

  // Next-state and output decisions; done and the strobe are pulses
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    width_d  = width_q;
    uns_d    = uns_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    exc_d    = exc_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_In) begin
          if (misalign) begin
            done_d   = 1'b1;
            exc_d    = `EXCEP_INVALID_MEM_READ;
            result_d = '0;
          end else begin
            addr_d  = addr_In;
            width_d = dataWidth_In;
            uns_d   = unsigned_In;
            valid_d = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (memException_In != `EXCEP_OK) begin
          exc_d    = memException_In;
          done_d   = 1'b1;
          result_d = '0;
          state_d  = S_IDLE;
        end else begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (memOK_In) begin
          result_d = ext;
          exc_d    = `EXCEP_OK;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          result_d = '0;
          exc_d    = `EXCEP_INVALID_MEM_READ;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      width_q  <= `MEM_WIDTH_NONE;
      uns_q    <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= `EXCEP_OK;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      width_q  <= width_d;
      uns_q    <= uns_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
